hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Parametrised hazard and forwarding controller for the pipelined CPU; it is the successor to the fixed two-stage forward/stall logic in the control unit. It generalises forwarding to FWD_DEPTH downstream stages with per-stage result-ready flags. It adds a scoreboard for multi-cycle (long-latency) operations, a branch-flush state machine with configurable squash slots, and saturating stall/flush performance counters. It sits beside the ID-stage decoder and drives the forward muxes, the IF/ID hold and the IF/ID squash.

Parameters:
REG_AW, 5, register-address width; register 0 is hardwired zero.
FWD_DEPTH, 2, number of forwardable stages downstream of ID (stage 1 = EX, youngest).
BR_SLOTS, 1, cycles of IF/ID squash after a taken branch (1..7).
MAX_LONG, 2, maximum outstanding long-latency ops (1..15).
CNT_W, 16, performance-counter width.

Ports:
Clk  in  1  clock.
Rst  in  1  asynchronous active-high reset.
ID_Valid  in  1  ID holds a real instruction.
ID_Rs, ID_Rt  in  REG_AW  ID source registers.
ID_UseRs, ID_UseRt  in  1  source is actually read.
ID_IsLong  in  1  ID instruction is a long-latency op.
ID_Rd  in  REG_AW  ID destination (used for long ops).
St_Rd  in  FWD_DEPTH*REG_AW  dest of stage i at bits [i*REG_AW-1 -: REG_AW].
St_Wreg  in  FWD_DEPTH  stage i writes a register.
St_Rdy  in  FWD_DEPTH  stage i result is available for forwarding.
Lng_Done  in  1  long unit wrote back this cycle.
Lng_DoneRd  in  REG_AW  register written by Lng_Done.
Br_Taken  in  1  EX resolved a taken branch/jump this cycle.
Clr_Cnt  in  1  synchronous clear of the performance counters.
FwdA, FwdB  out  $clog2(FWD_DEPTH+1)  0 = register file, i = stage i.
Stall  out  1  hold PC and IF/ID; insert a bubble into EX.
Flush  out  1  squash IF/ID contents.
Stall_Cnt, Flush_Cnt  out  CNT_W  performance counters.

Behaviour:
- Reset (asynchronous): FSM IDLE, slot counter 0, pending bitmap 0, outstanding count 0, both counters 0. Flush and Stall are 0 and FwdA/FwdB are 0.
- Forwarding is combinational. For each used source with a nonzero register number, the block selects the lowest stage i where St_Wreg[i] is set and St_Rd[i] equals the source. If no stage matches, the select is 0.
- Data hazard: the matched stage has St_Rdy = 0, giving load-use stall with no fixed latency.
- Scoreboard hazard: the pending bit for the source is set and no ready stage supplies it.
- Structural hazard: ID_IsLong is set and the outstanding count equals MAX_LONG.
- Stall = ID_Valid & ~Flush & (any hazard).
- Issue = ID_Valid & ~Stall & ~Flush.
- On Issue & ID_IsLong with ID_Rd != 0: set pending[ID_Rd] and increment the outstanding count.
- On Lng_Done: clear pending[Lng_DoneRd] and decrement the count. The count never goes below 0.
- Same register issued and done in the same cycle: the set wins and the count is unchanged.
- Flush FSM: IDLE -> SQUASH on Br_Taken, loading BR_SLOTS.
  - Flush = 1 combinationally in the Br_Taken cycle and in every SQUASH cycle while the counter is > 1.
  - The FSM returns to IDLE after BR_SLOTS total Flush cycles.
  - Br_Taken while in SQUASH reloads the counter.
  - Flush overrides Stall.
- Counters:
  - Stall_Cnt increments every cycle Stall = 1.
  - Flush_Cnt increments on each Br_Taken.
  - Both saturate at all-ones.
  - Clr_Cnt has priority over increment.
- Reset mid-operation discards all pending state. The pipeline is also reset, so no writeback is expected.

Decomposition:
- Package hazard_pkg holds the FSM state enum (IDLE, SQUASH) and the helper function for the forward-select width.
- The per-source priority match is instantiated twice as sub-module fwd_select (inputs: source, use, St_Rd/St_Wreg/St_Rdy; outputs: select, not-ready hit).

Test Plan:
- Stage 1 writes r5 ready, stage 2 writes r5 ready; ID_Rs=5 -> FwdA=1, Stall=0. Remove stage 1 -> FwdA=2.
- Stage 1 writes r7 with St_Rdy=0, ID_Rt=7 -> Stall=1 and Stall_Cnt +1. Next cycle St_Rdy=1 -> Stall=0, FwdB=1.
- Issue long op to r9 (MAX_LONG=2); next ID reads r9 -> Stall until Lng_Done with r9. Stall drops the cycle after Done; FwdA=0.
- Two long ops outstanding, third ID_IsLong -> Stall=1. Lng_Done -> issue proceeds, count returns to 2.
- BR_SLOTS=2: Br_Taken -> Flush high for 2 cycles, Stall=0 despite hazard, Flush_Cnt=1. Br_Taken again in the 2nd cycle -> Flush held 2 more.
- Rst pulsed with pending r3 and the FSM in SQUASH -> all outputs 0 and r3 reads without stall. Clr_Cnt zeroes both counters.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard/forwarding controller.
package hazard_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    SQUASH = 1'b1
  } flush_state_t;

  // Slot counter holds BR_SLOTS up to 7.
  localparam int SLOT_W = 3;

  function automatic int fwd_sel_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Per-source forward select: youngest (lowest-numbered) writing stage wins.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int REG_AW    = 5,
  parameter int FWD_DEPTH = 2,
  parameter int SEL_W     = fwd_sel_width(FWD_DEPTH)
) (
  input  logic [REG_AW-1:0]           src,
  input  logic                        use_src,
  input  logic [FWD_DEPTH*REG_AW-1:0] st_rd,
  input  logic [FWD_DEPTH-1:0]        st_wreg,
  input  logic [FWD_DEPTH-1:0]        st_rdy,
  output logic [SEL_W-1:0]            sel,
  output logic                        nrdy_hit
);

  logic [FWD_DEPTH-1:0] match;

  generate
    for (genvar gi = 0; gi < FWD_DEPTH; gi++) begin : g_match
      assign match[gi] = use_src && (src != '0) && st_wreg[gi] &&
                         (st_rd[gi*REG_AW +: REG_AW] == src);
    end
  endgenerate

  // Scan from the oldest stage down so the youngest match overwrites.
  always_comb begin
    sel      = '0;
    nrdy_hit = 1'b0;
    for (int i = FWD_DEPTH - 1; i >= 0; i--) begin
      if (match[i]) begin
        sel      = SEL_W'(i + 1);
        nrdy_hit = ~st_rdy[i];
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller: forward selects, stall/flush generation,
// long-op scoreboard, branch squash FSM and saturating perf counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW    = 5,
  parameter int FWD_DEPTH = 2,
  parameter int BR_SLOTS  = 1,
  parameter int MAX_LONG  = 2,
  parameter int CNT_W     = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 id_valid,
  input  logic [REG_AW-1:0]                    id_rs,
  input  logic [REG_AW-1:0]                    id_rt,
  input  logic                                 id_use_rs,
  input  logic                                 id_use_rt,
  input  logic                                 id_is_long,
  input  logic [REG_AW-1:0]                    id_rd,
  input  logic [FWD_DEPTH*REG_AW-1:0]          st_rd,
  input  logic [FWD_DEPTH-1:0]                 st_wreg,
  input  logic [FWD_DEPTH-1:0]                 st_rdy,
  input  logic                                 lng_done,
  input  logic [REG_AW-1:0]                    lng_done_rd,
  input  logic                                 br_taken,
  input  logic                                 clr_cnt,
  output logic [fwd_sel_width(FWD_DEPTH)-1:0]  fwd_a,
  output logic [fwd_sel_width(FWD_DEPTH)-1:0]  fwd_b,
  output logic                                 stall,
  output logic                                 flush,
  output logic [CNT_W-1:0]                     stall_cnt,
  output logic [CNT_W-1:0]                     flush_cnt
);

  localparam int SEL_W  = fwd_sel_width(FWD_DEPTH);
  localparam int LCNT_W = $clog2(MAX_LONG + 1);
  localparam int NREG   = 1 << REG_AW;

  // ---------------- forwarding ----------------
  logic [SEL_W-1:0] sel_a, sel_b;
  logic             nrdy_a, nrdy_b;

  fwd_select #(.REG_AW(REG_AW), .FWD_DEPTH(FWD_DEPTH), .SEL_W(SEL_W)) u_fwd_a (
    .src(id_rs), .use_src(id_use_rs), .st_rd(st_rd), .st_wreg(st_wreg),
    .st_rdy(st_rdy), .sel(sel_a), .nrdy_hit(nrdy_a)
  );

  fwd_select #(.REG_AW(REG_AW), .FWD_DEPTH(FWD_DEPTH), .SEL_W(SEL_W)) u_fwd_b (
    .src(id_rt), .use_src(id_use_rt), .st_rd(st_rd), .st_wreg(st_wreg),
    .st_rdy(st_rdy), .sel(sel_b), .nrdy_hit(nrdy_b)
  );

  assign fwd_a = sel_a;
  assign fwd_b = sel_b;

  // ---------------- scoreboard ----------------
  logic [NREG-1:0]   pending_reg, pending_next;
  logic [LCNT_W-1:0] out_cnt_reg, out_cnt_next;
  logic              sb_a, sb_b, data_hz, sb_hz, struct_hz, issue, long_set, long_clr;

  // A ready in-flight producer makes a pending bit irrelevant.
  assign sb_a = id_use_rs && (id_rs != '0) && pending_reg[id_rs] &&
                !((sel_a != '0) && !nrdy_a);
  assign sb_b = id_use_rt && (id_rt != '0) && pending_reg[id_rt] &&
                !((sel_b != '0) && !nrdy_b);

  assign data_hz   = nrdy_a | nrdy_b;
  assign sb_hz     = sb_a | sb_b;
  assign struct_hz = id_is_long && (out_cnt_reg == LCNT_W'(MAX_LONG));

  assign stall    = id_valid && !flush && (data_hz || sb_hz || struct_hz);
  assign issue    = id_valid && !stall && !flush;
  assign long_set = issue && id_is_long && (id_rd != '0);
  assign long_clr = lng_done && (out_cnt_reg != '0);

  always_comb begin
    pending_next = pending_reg;
    if (lng_done) pending_next[lng_done_rd] = 1'b0;
    if (long_set) pending_next[id_rd] = 1'b1;

    out_cnt_next = out_cnt_reg;
    if (long_set && !long_clr)      out_cnt_next = out_cnt_reg + LCNT_W'(1);
    else if (!long_set && long_clr) out_cnt_next = out_cnt_reg - LCNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_reg <= '0;
      out_cnt_reg <= '0;
    end else begin
      pending_reg <= pending_next;
      out_cnt_reg <= out_cnt_next;
    end
  end

  // ---------------- branch squash FSM ----------------
  flush_state_t      state_reg, state_next;
  logic [SLOT_W-1:0] slot_reg, slot_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      slot_reg  <= '0;
    end else begin
      state_reg <= state_next;
      slot_reg  <= slot_next;
    end
  end

  // The Br_Taken cycle is the first flush cycle, so SQUASH covers the rest.
  always_comb begin
    state_next = state_reg;
    slot_next  = slot_reg;
    case (state_reg)
      IDLE: begin
        if (br_taken) begin
          state_next = SQUASH;
          slot_next  = SLOT_W'(BR_SLOTS);
        end
      end
      SQUASH: begin
        if (br_taken) begin
          slot_next = SLOT_W'(BR_SLOTS);
        end else if (slot_reg > SLOT_W'(2)) begin
          slot_next = slot_reg - SLOT_W'(1);
        end else begin
          state_next = IDLE;
          slot_next  = '0;
        end
      end
      default: begin
        state_next = IDLE;
        slot_next  = '0;
      end
    endcase
  end

  always_comb begin
    flush = br_taken || ((state_reg == SQUASH) && (slot_reg > SLOT_W'(1)));
  end

  // ---------------- performance counters ----------------
  logic [CNT_W-1:0] perf_reg [2];
  logic [1:0]       perf_inc;

  assign perf_inc = {br_taken, stall};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_perf
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          perf_reg[gi] <= '0;
        end else if (clr_cnt) begin
          perf_reg[gi] <= '0;
        end else if (perf_inc[gi] && (perf_reg[gi] != '1)) begin
          perf_reg[gi] <= perf_reg[gi] + CNT_W'(1);
        end
      end
    end
  endgenerate

  assign stall_cnt = perf_reg[0];
  assign flush_cnt = perf_reg[1];

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (REG_AW=5, FWD_DEPTH=2, BR_SLOTS=2, MAX_LONG=2, CNT_W=4).
module tb_hazard_ctrl;

  localparam int REG_AW = 5;
  localparam int FWD_DEPTH = 2;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst;
  logic id_valid, id_use_rs, id_use_rt, id_is_long, lng_done, br_taken, clr_cnt;
  logic [REG_AW-1:0] id_rs, id_rt, id_rd, lng_done_rd;
  logic [FWD_DEPTH*REG_AW-1:0] st_rd;
  logic [FWD_DEPTH-1:0] st_wreg, st_rdy;
  logic [1:0] fwd_a, fwd_b;
  logic stall, flush;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .REG_AW(REG_AW), .FWD_DEPTH(FWD_DEPTH), .BR_SLOTS(2), .MAX_LONG(2), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_is_long(id_is_long),
    .id_rd(id_rd), .st_rd(st_rd), .st_wreg(st_wreg), .st_rdy(st_rdy),
    .lng_done(lng_done), .lng_done_rd(lng_done_rd), .br_taken(br_taken),
    .clr_cnt(clr_cnt), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall),
    .flush(flush), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("check %-14s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in;
    id_valid = 0; id_use_rs = 0; id_use_rt = 0; id_is_long = 0;
    id_rs = 0; id_rt = 0; id_rd = 0; lng_done = 0; lng_done_rd = 0;
    st_rd = '0; st_wreg = '0; st_rdy = '0; br_taken = 0; clr_cnt = 0;
  endtask

  initial begin
    rst = 1'b1;
    clear_in();
    #2;
    chk("rst_stall", stall, 0);
    chk("rst_flush", flush, 0);
    chk("rst_fwd_a", fwd_a, 0);
    chk("rst_fwd_b", fwd_b, 0);
    chk("rst_scnt", stall_cnt, 0);
    chk("rst_fcnt", flush_cnt, 0);
    cyc();
    rst = 1'b0;

    // Forwarding priority: youngest stage wins
    id_valid = 1; id_use_rs = 1; id_rs = 5;
    st_rd = {5'd5, 5'd5}; st_wreg = 2'b11; st_rdy = 2'b11;
    #1 chk("fwd_s1", fwd_a, 1);
    chk("fwd_nostall", stall, 0);
    st_wreg = 2'b10;
    #1 chk("fwd_s2", fwd_a, 2);
    id_rs = 0; st_rd = '0; st_wreg = 2'b11; st_rdy = 2'b00;
    #1 chk("fwd_r0", fwd_a, 0);
    chk("r0_nostall", stall, 0);

    // Load-use stall
    clear_in();
    id_valid = 1; id_use_rt = 1; id_rt = 7;
    st_rd = {5'd0, 5'd7}; st_wreg = 2'b01; st_rdy = 2'b00;
    #1 chk("lu_stall", stall, 1);
    cyc();
    st_rdy = 2'b01;
    #1 chk("lu_release", stall, 0);
    chk("lu_fwd_b", fwd_b, 1);
    chk("lu_scnt", stall_cnt, 1);

    // Scoreboard on r9
    clear_in();
    id_valid = 1; id_is_long = 1; id_rd = 9;
    #1 chk("long9_issue", stall, 0);
    cyc();
    id_is_long = 0; id_use_rs = 1; id_rs = 9;
    #1 chk("sb_stall", stall, 1);
    cyc();
    lng_done = 1; lng_done_rd = 9;
    #1 chk("sb_done_cyc", stall, 1);
    cyc();
    lng_done = 0;
    #1 chk("sb_release", stall, 0);
    chk("sb_fwd_a", fwd_a, 0);
    chk("sb_scnt", stall_cnt, 3);

    // Structural limit of two outstanding long ops
    clear_in();
    id_valid = 1; id_is_long = 1; id_rd = 10;
    cyc();
    id_rd = 11;
    #1 chk("long11_issue", stall, 0);
    cyc();
    id_rd = 12;
    #1 chk("struct_stall", stall, 1);
    cyc();
    lng_done = 1; lng_done_rd = 10;
    #1 chk("struct_done", stall, 1);
    cyc();
    lng_done = 0;
    #1 chk("struct_go", stall, 0);
    cyc();
    id_rd = 13;
    #1 chk("struct_full2", stall, 1);
    chk("struct_scnt", stall_cnt, 5);
    id_is_long = 0; id_use_rs = 1; id_rs = 12;
    #1 chk("pend12", stall, 1);
    st_rd = {5'd0, 5'd12}; st_wreg = 2'b01; st_rdy = 2'b01;
    #1 chk("pend12_fwd", stall, 0);
    chk("pend12_sel", fwd_a, 1);
    clear_in();
    id_valid = 1; id_rt = 11; id_use_rt = 0;
    #1 chk("pend_unused", stall, 0);

    // Branch squash with a pending data hazard
    clear_in();
    id_valid = 1; id_use_rt = 1; id_rt = 7;
    st_rd = {5'd0, 5'd7}; st_wreg = 2'b01; st_rdy = 2'b00;
    br_taken = 1;
    #1 chk("br_flush0", flush, 1);
    chk("br_nostall0", stall, 0);
    cyc();
    br_taken = 0;
    #1 chk("br_flush1", flush, 1);
    chk("br_nostall1", stall, 0);
    chk("br_fcnt", flush_cnt, 1);
    cyc();
    #1 chk("br_flush2", flush, 0);
    chk("br_stall2", stall, 1);
    br_taken = 1;
    #1 chk("br2_flush0", flush, 1);
    cyc();
    #1 chk("br2_reload", flush, 1);
    cyc();
    br_taken = 0;
    #1 chk("br2_held", flush, 1);
    cyc();
    #1 chk("br2_end", flush, 0);
    chk("br2_fcnt", flush_cnt, 3);
    chk("br2_scnt", stall_cnt, 5);

    // Asynchronous reset with r3 pending and FSM in SQUASH
    clear_in();
    lng_done = 1; lng_done_rd = 11;
    cyc();
    lng_done = 0; id_valid = 1; id_is_long = 1; id_rd = 3;
    cyc();
    clear_in();
    br_taken = 1;
    cyc();
    br_taken = 0;
    #1 chk("pre_rst_flush", flush, 1);
    #2 rst = 1;
    #1 chk("arst_flush", flush, 0);
    chk("arst_scnt", stall_cnt, 0);
    chk("arst_fcnt", flush_cnt, 0);
    cyc();
    rst = 0;
    id_valid = 1; id_use_rs = 1; id_rs = 3;
    #1 chk("arst_r3", stall, 0);
    id_use_rs = 0; id_is_long = 1; id_rd = 4;
    #1 chk("arst_long", stall, 0);

    // Saturation and clear priority
    clear_in();
    id_valid = 1; id_use_rt = 1; id_rt = 7;
    st_rd = {5'd0, 5'd7}; st_wreg = 2'b01; st_rdy = 2'b00;
    repeat (20) cyc();
    chk("scnt_sat", stall_cnt, 15);
    br_taken = 1;
    repeat (17) cyc();
    chk("fcnt_sat", flush_cnt, 15);
    chk("scnt_hold", stall_cnt, 15);
    clr_cnt = 1;
    cyc();
    chk("clr_scnt", stall_cnt, 0);
    chk("clr_fcnt", flush_cnt, 0);
    clr_cnt = 0;
    cyc();
    chk("post_clr_fcnt", flush_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
